// File: rtl/set_cmd_loader_if.sv
// Byte-stream command input and SET engine issue port of the command loader.
interface set_cmd_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        set_busy;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;

    // Host and engine side: drives bytes and busy, observes ready and issued command
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output set_busy,
        input  set_en,
        input  set_central,
        input  set_radius,
        input  set_mode
    );

    // Loader side
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  set_busy,
        output set_en,
        output set_central,
        output set_radius,
        output set_mode
    );
endinterface

// File: rtl/set_cmd_loader.sv
// Command front-end for the SET circle-counting engine.
// Assembles 6-byte packets {B0={hdr,mode}, B1..B3=central, B4[3:0]/B5=radius}
// into 38-bit commands, buffers DEPTH of them and issues the head entry with a
// one-cycle set_en whenever the engine is not busy.
// Optional: define SET_CMD_HDR_CHECK_EN to drop packets whose B0[7:2] is not
// 6'b101001 and pulse err for one cycle on the dropped packet's last byte.
module set_cmd_loader #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    set_cmd_loader_if.slave         bus,
    output logic [$clog2(DEPTH):0]  q_level,
    output logic                    err
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned LW       = AW + 1;
    localparam int unsigned SW       = 40;
    localparam logic [2:0]  LAST_IDX = 3'd5;

    typedef struct packed {
        logic [1:0]  mode;
        logic [23:0] central;
        logic [11:0] radius;
    } cmd_t;

    logic [2:0]    byte_idx;
    logic [SW-1:0] shift_q;
    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [LW-1:0] level_q;
    cmd_t          entry;
    cmd_t          head;
    logic          xfer;
    logic          last_xfer;
    logic          hdr_ok;
    logic          push;
    logic          pop;
    logic          full;
    logic          sink_unused;

    // B0..B4 sit in the shift register; B5 joins them directly off the bus
    assign entry.mode    = shift_q[33:32];
    assign entry.central = shift_q[31:8];
    assign entry.radius  = {shift_q[3:0], bus.in_data};

    // Upper nibble of B4 carries no information; header bits are only
    // inspected when the header check is built in
    assign sink_unused = ^{shift_q[39:34], shift_q[7:4]};

    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Only the final byte can stall; a same-cycle pop frees a slot for it
    assign bus.in_ready = (byte_idx != LAST_IDX) || !full || bus.set_en;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign last_xfer = xfer && (byte_idx == LAST_IDX);
    assign push      = last_xfer && hdr_ok;

    // Issue whenever a command is waiting and the engine is sampling
    assign bus.set_en = (level_q != '0) && !bus.set_busy;
    assign pop        = bus.set_en;

    assign head            = mem[rd_ptr[AW-1:0]];
    assign bus.set_central = head.central;
    assign bus.set_radius  = head.radius;
    assign bus.set_mode    = head.mode;

    assign q_level = level_q;

`ifdef SET_CMD_HDR_CHECK_EN
    localparam logic [5:0] HDR_GOOD = 6'b101001;

    assign hdr_ok = (shift_q[39:34] == HDR_GOOD);

    // One-cycle drop indication following the last byte of a bad packet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= last_xfer && !hdr_ok;
        end
    end
`else
    assign hdr_ok = 1'b1;
    assign err    = 1'b0;
`endif

    // Byte position within the packet and accumulation of B0..B4
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= '0;
            shift_q  <= '0;
        end else if (xfer) begin
            if (byte_idx == LAST_IDX) begin
                byte_idx <= '0;
            end else begin
                byte_idx <= byte_idx + 3'd1;
                shift_q  <= {shift_q[SW-9:0], bus.in_data};
            end
        end
    end

    // Command storage; cleared on reset so the head outputs read as zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= entry;
        end
    end

    // Read/write pointers (with wrap bit) and stored-command count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end
endmodule
